timer_device: RTL



---
 rtl/timer_device_pkg.sv | 31 +++
 rtl/timer_device.sv | 106 ++++++++++
 2 files changed

// File: rtl/timer_device_pkg.sv
// Shared constants for the memory-mapped interval timer: register map,
// CTRL bit layout, mode encodings and the FSM state encoding.
package timer_device_pkg;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;  // two bits, [2:1]
  localparam int CTRL_IM   = 3;

  localparam logic [1:0] MODE_ONESHOT     = 2'b00;
  localparam logic [1:0] MODE_AUTO_RELOAD = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tmr_state_e;

  // Layout matches the CTRL bit positions so a zero-extend gives the read value.
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

endpackage

// File: rtl/timer_device.sv
// Interval timer on the data-memory bus: CTRL/PRESET/COUNT registers,
// one-shot or auto-reload countdown and a maskable interrupt request.
module timer_device
  import timer_device_pkg::*;
#(
  parameter int         CNT_W       = 32,
  parameter logic [1:0] MODE_RELOAD = MODE_AUTO_RELOAD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  ctrl_t              r_ctrl;
  logic [CNT_W-1:0]   r_preset;
  logic [CNT_W-1:0]   r_count;
  logic               r_irq_flag;
  tmr_state_e         r_state;
  tmr_state_e         w_state_nxt;

  logic w_wr_ctrl, w_wr_preset;
  logic w_cnt_gt1, w_reload;
  logic w_load, w_dec, w_expire, w_en_clr, w_flag_clr;

  assign w_wr_ctrl   = sel & we & (addr == OFF_CTRL);
  assign w_wr_preset = sel & we & (addr == OFF_PRESET);
  assign w_cnt_gt1   = r_count > CNT_W'(1);
  assign w_reload    = (r_ctrl.mode == MODE_RELOAD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (r_ctrl.en) w_state_nxt = ST_LOAD;
      ST_LOAD: w_state_nxt = ST_CNT;
      ST_CNT: begin
        if (!r_ctrl.en)      w_state_nxt = ST_IDLE;
        else if (!w_cnt_gt1) w_state_nxt = ST_INT;
      end
      ST_INT: begin
        if (!r_ctrl.en || !w_reload) w_state_nxt = ST_IDLE;
        else                         w_state_nxt = ST_LOAD;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_load     = (r_state == ST_LOAD);
    w_dec      = (r_state == ST_CNT) & r_ctrl.en & w_cnt_gt1;
    w_expire   = (r_state == ST_CNT) & r_ctrl.en & ~w_cnt_gt1;
    w_en_clr   = (r_state == ST_INT) & r_ctrl.en & ~w_reload;
    w_flag_clr = (r_state == ST_INT) & r_ctrl.en & w_reload;
  end

  // Bus writes to CTRL take priority over the FSM's own CTRL/flag updates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl     <= '0;
      r_preset   <= '0;
      r_count    <= '0;
      r_irq_flag <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_ctrl.en   <= wdata[CTRL_EN];
        r_ctrl.mode <= wdata[CTRL_MODE +: 2];
        r_ctrl.im   <= wdata[CTRL_IM];
      end else if (w_en_clr) begin
        r_ctrl.en <= 1'b0;
      end

      if (w_wr_preset) r_preset <= wdata[CNT_W-1:0];

      if (w_load)        r_count <= r_preset;
      else if (w_dec)    r_count <= r_count - CNT_W'(1);
      else if (w_expire) r_count <= '0;

      if (w_wr_ctrl || w_flag_clr) r_irq_flag <= 1'b0;
      else if (w_expire)           r_irq_flag <= 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr)
        OFF_CTRL:   rdata = 32'(r_ctrl);
        OFF_PRESET: rdata = 32'(r_preset);
        OFF_COUNT:  rdata = 32'(r_count);
        default:    rdata = '0;
      endcase
    end
  end

  assign irq = r_irq_flag & r_ctrl.im;

endmodule
